demux_sched: RTL and testbench



---
 rtl/demux_sched_pkg.sv | 21 ++
 rtl/demux_sched_if.sv | 31 +++
 rtl/demux_sched_rr_sel.sv | 57 +++++
 rtl/demux_sched.sv | 83 ++++++++
 tb/tb_demux_sched.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/demux_sched_pkg.sv
// Shared definitions for demux_sched: FSM state encoding, counter width and a width helper.
package demux_sched_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int CNT_W = 16;

    // Smallest width that can index n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_sched_if.sv
// Stream-in / N-channel-out bus of demux_sched; master drives the input stream and channel readies.
interface demux_sched_if #(
    parameter int N_OUT = 2,
    parameter int DW    = 1
);
    import demux_sched_pkg::*;

    localparam int SELW = clog2_min1(N_OUT);

    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [SELW-1:0]  in_sel;
    logic [DW-1:0]    out_data;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;
    logic             sel_err;
    logic [CNT_W-1:0] sent_cnt;

    modport master (
        output in_data, in_valid, mode, in_sel, out_ready,
        input  in_ready, out_data, out_valid, sel_err, sent_cnt
    );

    modport slave (
        input  in_data, in_valid, mode, in_sel, out_ready,
        output in_ready, out_data, out_valid, sel_err, sent_cnt
    );

endinterface

// File: rtl/demux_sched_rr_sel.sv
// Round-robin pointer and next-target choice; DEMUX_SCHED_SKIP_BUSY_EN skips channels not ready.
module demux_rr_sel
    import demux_sched_pkg::*;
#(
    parameter  int N_OUT = 2,
    localparam int SELW  = clog2_min1(N_OUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [N_OUT-1:0] out_ready,
    output logic [SELW-1:0]  tgt_next,
    output logic [SELW-1:0]  ptr
);

    logic [SELW-1:0] ptr_q, ptr_d;

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] v);
        return (int'(v) == N_OUT - 1) ? '0 : v + 1'b1;
    endfunction

`ifdef DEMUX_SCHED_SKIP_BUSY_EN
    logic [SELW-1:0] idx;
    logic            found;

    // First ready channel at or after ptr; falls back to ptr when all are busy.
    always_comb begin
        tgt_next = ptr_q;
        found    = 1'b0;
        idx      = ptr_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (!found && out_ready[idx]) begin
                tgt_next = idx;
                found    = 1'b1;
            end
            idx = wrap_inc(idx);
        end
    end
`else
    logic unused_out_ready;
    assign unused_out_ready = ^out_ready;
    assign tgt_next = ptr_q;
`endif

    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = wrap_inc(tgt_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/demux_sched.sv
// 1-to-N stream demux controller with a one-word buffer; round-robin or explicit channel select.
// Optional DEMUX_SCHED_SKIP_BUSY_EN makes round-robin skip channels that are not ready.
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter  int N_OUT = 2,
    parameter  int DW    = 1,
    localparam int SELW  = clog2_min1(N_OUT)
) (
    input  logic          clk,
    input  logic          rst,
    demux_sched_if.slave  bus
);

    state_e           state_q, state_d;
    logic [DW-1:0]    data_q, data_d;
    logic [SELW-1:0]  tgt_q, tgt_d;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SELW-1:0]  rr_tgt;
    logic [SELW-1:0]  rr_ptr_unused;
    logic             accept, complete, sel_bad;

    assign complete     = (state_q == ST_FULL) && bus.out_ready[tgt_q];
    assign bus.in_ready = !rst && ((state_q == ST_EMPTY) || bus.out_ready[tgt_q]);
    assign accept       = bus.in_valid && bus.in_ready;
    assign sel_bad      = bus.mode && (int'(bus.in_sel) >= N_OUT);

    demux_rr_sel #(.N_OUT(N_OUT)) u_rr_sel (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept && !bus.mode),
        .out_ready (bus.out_ready),
        .tgt_next  (rr_tgt),
        .ptr       (rr_ptr_unused)
    );

    // A completing word and a new accept share the edge, so refill wins over going EMPTY.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        tgt_d     = tgt_q;
        sel_err_d = sel_err_q | (accept & sel_bad);
        cnt_d     = complete ? cnt_q + 1'b1 : cnt_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = bus.in_data;
            if (!bus.mode)   tgt_d = rr_tgt;
            else if (sel_bad) tgt_d = '0;
            else             tgt_d = bus.in_sel;
        end else if (complete) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            tgt_q     <= '0;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            tgt_q     <= tgt_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        bus.out_valid = '0;
        for (int k = 0; k < N_OUT; k++) begin
            bus.out_valid[k] = (state_q == ST_FULL) && (tgt_q == SELW'(k));
        end
    end

    assign bus.out_data = data_q;
    assign bus.sel_err  = sel_err_q;
    assign bus.sent_cnt = cnt_q;

endmodule

// File: tb/tb_demux_sched.sv
// Scoreboard bench for demux_sched (N_OUT=3, DW=8): directed cases followed by random traffic.
module tb_demux_sched;
    import demux_sched_pkg::*;

    localparam int N  = 3;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] d;
        int            ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_sched_if #(.N_OUT(N), .DW(DW)) bus();

    demux_sched #(.N_OUT(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    // Reference state: whether a word is pending, where it goes, and the rotation position.
    bit            m_full;
    int            m_tgt;
    int            m_ptr;
    bit            m_err;
    int            m_sent;
    logic [DW-1:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_target(input bit md, input int sel);
        if (md) return (sel < N) ? sel : 0;
`ifdef DEMUX_SCHED_SKIP_BUSY_EN
        for (int i = 0; i < N; i++) begin
            if (bus.out_ready[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
`endif
        return m_ptr;
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_tgt  = 0;
        m_ptr  = 0;
        m_err  = 0;
        m_sent = 0;
        m_data = '0;
        sb_q.delete();
    endtask

    // Called just after a rising edge; drives one cycle and checks state after the next edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit md,
                        input logic [1:0] sel, input logic [N-1:0] ordy);
        bit exp_rdy, acc, cmpl;
        int t;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.mode      = md;
        bus.in_sel    = sel;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !m_full || ordy[m_tgt];
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        acc  = v && exp_rdy;
        cmpl = m_full && ordy[m_tgt];
        if (cmpl) begin
            m_sent++;
            m_full = 0;
        end
        if (acc) begin
            t = model_target(md, int'(sel));
            if (md && int'(sel) >= N) m_err = 1;
            if (!md) m_ptr = (t + 1) % N;
            m_full = 1;
            m_tgt  = t;
            m_data = d;
            sb_q.push_back('{d: d, ch: t});
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus.out_valid), m_full ? (32'd1 << m_tgt) : 32'd0);
        if (m_full) check("out_data", 32'(bus.out_data), 32'(m_data));
        check("sent_cnt", 32'(bus.sent_cnt), 32'(m_sent & 16'hFFFF));
        check("sel_err", {31'd0, bus.sel_err}, {31'd0, m_err});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every output handshake must match the oldest accepted word.
    always @(negedge clk) begin
        if (rst === 1'b0 && |(bus.out_valid & bus.out_ready)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: out_valid %0h with no word expected", bus.out_valid);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_chan", 32'(bus.out_valid), 32'd1 << mon_e.ch);
                check("sb_data", 32'(bus.out_data), 32'(mon_e.d));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 1'b0;
        bus.in_sel    = '0;
        bus.out_ready = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_sent_cnt", 32'(bus.sent_cnt), 32'd0);
        rst = 1'b0;

        step(0, 8'h00, 0, 2'd0, 3'b000);
        step(0, 8'h00, 0, 2'd0, 3'b000);

        // Back-to-back round robin with every channel ready.
        step(1, 8'h11, 0, 2'd0, 3'b111);
        step(1, 8'h22, 0, 2'd0, 3'b111);
        step(1, 8'h33, 0, 2'd0, 3'b111);
        step(1, 8'h44, 0, 2'd0, 3'b111);
        step(0, 8'h00, 0, 2'd0, 3'b111);
        step(0, 8'h00, 0, 2'd0, 3'b111);

        // Explicit select to a channel that is not ready, then release it.
        step(1, 8'h5A, 1, 2'd1, 3'b001);
        for (int i = 0; i < 3; i++) step(1, 8'hEE, 1, 2'd2, 3'b001);
        step(0, 8'h00, 1, 2'd0, 3'b111);
        step(0, 8'h00, 1, 2'd0, 3'b111);

        // Out-of-range select lands on channel 0 and sets the sticky flag.
        step(1, 8'hC3, 1, 2'd3, 3'b000);
        step(0, 8'h00, 1, 2'd0, 3'b001);
        step(1, 8'h3C, 1, 2'd2, 3'b111);
        step(0, 8'h00, 0, 2'd0, 3'b111);

        // Backpressure on channel 0 while a new word waits.
        step(1, 8'hA5, 1, 2'd0, 3'b000);
        for (int i = 0; i < 5; i++) step(1, 8'h77, 0, 2'd1, 3'b000);
        step(0, 8'h00, 0, 2'd0, 3'b001);

        // Round robin from pointer 0 with only channel 1 ready.
        apply_reset();
        step(1, 8'h81, 0, 2'd0, 3'b010);
        step(1, 8'h82, 0, 2'd0, 3'b111);
        step(1, 8'h83, 0, 2'd0, 3'b111);
        step(0, 8'h00, 0, 2'd0, 3'b111);

        // Reset while holding a word discards it.
        step(1, 8'h99, 1, 2'd2, 3'b000);
        apply_reset();
        step(0, 8'h00, 0, 2'd0, 3'b111);

        for (int c = 0; c < 400; c++) begin
            if (c == 200) apply_reset();
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), N'($urandom));
        end

        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 2'd0, 3'b111);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
